// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - instruction prefetch FIFO and fetch/decode pipeline register
//
// Purpose:
//   Buffers instructions returned by the fetch port in a DEPTH-entry ring of
//   {addr, inst} and presents them, in fetch order, through a registered
//   output stage to the id stage. An empty buffer forwards a fetch straight
//   into the output register (1-cycle fetch-to-id latency). hold_i freezes
//   the output register while the buffer keeps accepting fetches.
//   jump_flag_i discards everything, buffered or presented.
//
// Optional feature (macro IF_FIFO_STATS_EN):
//   Adds flush_drop_cnt_o, a saturating count of flushes that discarded at
//   least one real instruction. Without the macro the port does not exist.
//
// Ports:
//   clk               clock
//   rst               synchronous reset, active-high (wins over jump_flag_i)
//   fetch_valid_i     fetch port returns an instruction this cycle
//   fetch_ready_o     buffer can accept a fetch (count != DEPTH)
//   inst_i            fetched instruction
//   inst_addr_i       address of inst_i
//   hold_i            stall: freeze the output register
//   jump_flag_i       flush: drop all buffered and presented state
//   inst_o            registered instruction to id (NOP_INST when invalid)
//   inst_addr_o       registered address to id (0 when invalid)
//   inst_valid_o      inst_o/inst_addr_o hold a real instruction
//   flush_drop_cnt_o  (IF_FIFO_STATS_EN only) saturating dropped-flush count

module if_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        hold_i,
  input  logic        jump_flag_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
`ifdef IF_FIFO_STATS_EN
  ,
  output logic [31:0] flush_drop_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [31:0]   inst_q;
  logic [31:0]   addr_q;
  logic          valid_q;

  logic          empty;
  logic          adv;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          wr_en;
  logic [63:0]   head;

  // Ready depends only on occupancy, so the fetcher never sees a
  // combinational path from hold_i or from the id side.
  assign fetch_ready_o = (count != FULL);
  assign empty         = (count == '0);
  assign adv           = ~hold_i;
  assign push          = fetch_valid_i & fetch_ready_o & ~jump_flag_i;
  assign pop           = adv & ~empty & ~jump_flag_i;
  // An empty buffer with an advancing output skips storage entirely.
  assign bypass        = adv & empty & push;
  assign wr_en         = push & ~bypass;
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || jump_flag_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Simultaneous write and pop leaves occupancy unchanged.
      if (wr_en && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !wr_en) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= {inst_addr_i, inst_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || jump_flag_i) begin
      inst_q  <= NOP_INST;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else if (adv) begin
      if (!empty) begin
        addr_q  <= head[63:32];
        inst_q  <= head[31:0];
        valid_q <= 1'b1;
      end else if (push) begin
        addr_q  <= inst_addr_i;
        inst_q  <= inst_i;
        valid_q <= 1'b1;
      end else begin
        addr_q  <= '0;
        inst_q  <= NOP_INST;
        valid_q <= 1'b0;
      end
    end
  end

  assign inst_o       = inst_q;
  assign inst_addr_o  = addr_q;
  assign inst_valid_o = valid_q;

`ifdef IF_FIFO_STATS_EN
  logic [31:0] flush_drop_cnt_q;
  logic        drop;

  // Only flushes that actually discard something are counted.
  assign drop = jump_flag_i & (~empty | valid_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_drop_cnt_q <= '0;
    end else if (drop && (flush_drop_cnt_q != 32'hFFFF_FFFF)) begin
      flush_drop_cnt_q <= flush_drop_cnt_q + 32'd1;
    end
  end

  assign flush_drop_cnt_o = flush_drop_cnt_q;
`endif

  // Occupancy never exceeds the ring, and the pointer distance always
  // matches the count modulo DEPTH.
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= FULL);
  a_ptr_count: assert property (@(posedge clk) disable iff (rst)
    PW'(wr_ptr - rd_ptr) == PW'(count));

endmodule

// File: tb/tb_if_fifo.sv
// tb/tb_if_fifo.sv - self-checking bench for if_fifo against a queue model

module tb_if_fifo;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        hold_i;
  logic        jump_flag_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
`ifdef IF_FIFO_STATS_EN
  logic [31:0] flush_drop_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue plus the expected output register.
  logic [63:0] m_q[$];
  logic [31:0] m_inst;
  logic [31:0] m_addr;
  logic        m_valid;
  logic [31:0] m_drops;
  logic        obs_ready;
  logic        exp_ready;

  if_fifo #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .hold_i        (hold_i),
    .jump_flag_i   (jump_flag_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o)
`ifdef IF_FIFO_STATS_EN
    ,
    .flush_drop_cnt_o (flush_drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, sample ready, advance the model, then return
  // on the following falling edge with the DUT outputs settled.
  task automatic step(input logic r, input logic fv, input logic [31:0] ins,
                      input logic [31:0] ad, input logic h, input logic j);
    logic do_push;
    rst = r; fetch_valid_i = fv; inst_i = ins; inst_addr_i = ad;
    hold_i = h; jump_flag_i = j;
    #1;
    obs_ready = fetch_ready_o;
    exp_ready = (m_q.size() != DEPTH);
    if (r) begin
      m_q.delete();
      m_inst = NOP; m_addr = '0; m_valid = 1'b0; m_drops = '0;
    end else if (j) begin
      if ((m_q.size() != 0 || m_valid) && m_drops != 32'hFFFF_FFFF) m_drops++;
      m_q.delete();
      m_inst = NOP; m_addr = '0; m_valid = 1'b0;
    end else begin
      do_push = fv && exp_ready;
      if (!h) begin
        if (m_q.size() != 0) begin
          {m_addr, m_inst} = m_q.pop_front();
          m_valid = 1'b1;
          if (do_push) m_q.push_back({ad, ins});
        end else if (do_push) begin
          m_addr = ad; m_inst = ins; m_valid = 1'b1;
        end else begin
          m_addr = '0; m_inst = NOP; m_valid = 1'b0;
        end
      end else if (do_push) begin
        m_q.push_back({ad, ins});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    rst = 1'b0; fetch_valid_i = 1'b0;
    #1;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", inst_valid_o); end
    checks++; if (inst_o !== 32'h13) begin errors++; $display("FAIL reset_inst: got %h exp 00000013", inst_o); end
    checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", inst_addr_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", fetch_ready_o); end
`ifdef IF_FIFO_STATS_EN
    checks++; if (flush_drop_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_drops: got %h exp 0", flush_drop_cnt_o); end
`endif
  endtask

  task automatic test_bypass();
    step(1'b0, 1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b exp 1", obs_ready); end
    checks++; if (inst_o !== 32'h00500093) begin errors++; $display("FAIL bypass_inst: got %h exp 00500093", inst_o); end
    checks++; if (inst_addr_o !== 32'h100) begin errors++; $display("FAIL bypass_addr: got %h exp 100", inst_addr_o); end
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b exp 1", inst_valid_o); end
    // Nothing was buffered, so the next idle cycle shows an invalid output.
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL bypass_empty_after: got %b exp 0", inst_valid_o); end
  endtask

  task automatic test_fill_hold();
    logic [31:0] ins [5];
    for (int i = 0; i < 5; i++) begin
      ins[i] = $urandom;
      step(1'b0, 1'b1, ins[i], 32'(4 * i), 1'b1, 1'b0);
      checks++; if (obs_ready !== (i < 4)) begin errors++; $display("FAIL fill_ready[%0d]: got %b exp %b", i, obs_ready, (i < 4)); end
    end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full: got %b exp 0", fetch_ready_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fill_held_valid: got %b exp 0", inst_valid_o); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++; if (inst_addr_o !== 32'(4 * k)) begin errors++; $display("FAIL drain_addr[%0d]: got %h exp %h", k, inst_addr_o, 32'(4 * k)); end
      checks++; if (inst_o !== ins[k]) begin errors++; $display("FAIL drain_inst[%0d]: got %h exp %h", k, inst_o, ins[k]); end
      checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b exp 1", k, inst_valid_o); end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL drain_end_valid: got %b exp 0", inst_valid_o); end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, $urandom, 32'h200, 1'b1, 1'b0);
    step(1'b0, 1'b1, $urandom, 32'h204, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, $urandom, 32'(32'h208 + 4 * k), 1'b0, 1'b0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp 1", k, obs_ready); end
      checks++; if (inst_addr_o !== 32'(32'h200 + 4 * k)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h exp %h", k, inst_addr_o, 32'(32'h200 + 4 * k)); end
      checks++; if (inst_o !== m_inst) begin errors++; $display("FAIL b2b_inst[%0d]: got %h exp %h", k, inst_o, m_inst); end
    end
    for (int k = 8; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++; if (inst_addr_o !== 32'(32'h200 + 4 * k) || inst_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_tail[%0d]: got %h/%b exp %h/1", k, inst_addr_o, inst_valid_o, 32'(32'h200 + 4 * k)); end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b exp 0", inst_valid_o); end
  endtask

  task automatic test_flush();
    step(1'b0, 1'b1, 32'h00A00113, 32'h300, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 32'(32'h304 + 4 * i), 1'b1, 1'b0);
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h300) begin errors++; $display("FAIL flush_pre: got %b/%h exp 1/300", inst_valid_o, inst_addr_o); end
    step(1'b0, 1'b1, $urandom, 32'h310, 1'b1, 1'b1);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", inst_valid_o); end
    checks++; if (inst_o !== 32'h13) begin errors++; $display("FAIL flush_inst: got %h exp 00000013", inst_o); end
    checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL flush_addr: got %h exp 0", inst_addr_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", fetch_ready_o); end
`ifdef IF_FIFO_STATS_EN
    checks++; if (flush_drop_cnt_o !== 32'd1) begin errors++; $display("FAIL flush_drops: got %h exp 1", flush_drop_cnt_o); end
`endif
    // The fetch in the flush cycle and the buffered entries are gone.
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty_after: got %b exp 0", inst_valid_o); end
  endtask

  task automatic test_flush_empty();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty_valid: got %b exp 0", inst_valid_o); end
`ifdef IF_FIFO_STATS_EN
    checks++; if (flush_drop_cnt_o !== 32'd1) begin errors++; $display("FAIL flush_empty_drops: got %h exp 1", flush_drop_cnt_o); end
    step(1'b0, 1'b1, $urandom, 32'h400, 1'b1, 1'b0);
    force dut.flush_drop_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.flush_drop_cnt_q;
    m_drops = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++; if (flush_drop_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL drops_saturate: got %h exp ffffffff", flush_drop_cnt_o); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom, a,
           $urandom_range(2) == 0, $urandom_range(15) == 0);
      a += 32'd4;
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b exp %b", n, obs_ready, exp_ready); end
      checks++; if (inst_valid_o !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b exp %b", n, inst_valid_o, m_valid); end
      checks++; if (inst_o !== m_inst) begin errors++; $display("FAIL rand_inst[%0d]: got %h exp %h", n, inst_o, m_inst); end
      checks++; if (inst_addr_o !== m_addr) begin errors++; $display("FAIL rand_addr[%0d]: got %h exp %h", n, inst_addr_o, m_addr); end
`ifdef IF_FIFO_STATS_EN
      checks++; if (flush_drop_cnt_o !== m_drops) begin errors++; $display("FAIL rand_drops[%0d]: got %h exp %h", n, flush_drop_cnt_o, m_drops); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; fetch_valid_i = 1'b0; inst_i = '0; inst_addr_i = '0;
    hold_i = 1'b0; jump_flag_i = 1'b0;
    m_inst = NOP; m_addr = '0; m_valid = 1'b0; m_drops = '0;
    @(negedge clk);
    test_reset();
    test_bypass();
    test_fill_hold();
    test_back_to_back();
    test_flush();
    test_flush_empty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
